// File: rtl/timer_axi.sv
// 32-bit down-counting timer with an AXI4-Lite slave register interface.
// Supports one-shot/periodic counting, compare, input capture, external
// event counting, PWM, a zero-event trigger pulse and a level interrupt.
//
// Write FSM state | meaning
//   W_IDLE        | waiting for awvalid
//   W_AW          | awready high, address accepted on awvalid
//   W_W           | wready high, register updated on wvalid
//   W_B           | bvalid high until bready
// Read FSM state  | meaning
//   R_IDLE        | waiting for arvalid
//   R_AR          | arready high, rdata latched on arvalid
//   R_DATA        | rvalid high until rready
module timer_axi #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        ext_meas_i,
    input  logic        capture_i,
    output logic        pwm_o,
    output logic        trigger_o,
    output logic        irq
);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA}    r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [2:0]  w_sel;
    logic [3:0]  ctrl;
    logic [31:0] load, count, capture, cmp;
    logic [2:0]  stat, int_en;
    logic [SYNC_STAGES-1:0] ext_sync, cap_sync;
    logic ext_prev, cap_prev;
    logic [31:0] rd_mux;
    logic [31:0] ctrl_wval, load_wval, int_en_wval, cmp_wval;
    logic wr_fire, ctrl_wr, en_start, run, tick, zero_evt, cmp_evt;
    logic ext_rise, cap_rise;
    logic [2:0] stat_clr, stat_set;
    logic unused_ok;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return res;
    endfunction

    assign bresp = 2'b00;
    assign rresp = 2'b00;
    assign irq   = |(stat & int_en);
    assign unused_ok = ^{awprot, arprot, awaddr[31:5], awaddr[1:0],
                         araddr[31:5], araddr[1:0]};

    // Write and read state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write channel next state and handshake outputs.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: if (awvalid) w_next = W_AW;
            W_AW: begin
                awready = 1'b1;
                if (awvalid) w_next = W_W;
            end
            W_W: begin
                wready = 1'b1;
                if (wvalid) w_next = W_B;
            end
            default: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
        endcase
    end

    // Read channel next state and handshake outputs.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: if (arvalid) r_next = R_AR;
            R_AR: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            default: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
        endcase
    end

    // Read data decode.
    always_comb begin
        rd_mux = 32'd0;
        case (araddr[4:2])
            3'd0: rd_mux = {28'd0, ctrl};
            3'd1: rd_mux = load;
            3'd2: rd_mux = count;
            3'd3: rd_mux = {29'd0, stat};
            3'd4: rd_mux = {29'd0, int_en};
            3'd5: rd_mux = capture;
            3'd6: rd_mux = cmp;
            default: rd_mux = 32'd0;
        endcase
    end

    // Latch write address and read data at their address handshakes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_sel <= 3'd0;
            rdata <= 32'd0;
        end else begin
            if (w_state == W_AW && awvalid) w_sel <= awaddr[4:2];
            if (r_state == R_AR && arvalid) rdata <= rd_mux;
        end
    end

    // Input synchronizers with rising-edge history.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ext_sync <= '0;
            cap_sync <= '0;
            ext_prev <= 1'b0;
            cap_prev <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_meas_i};
            cap_sync <= {cap_sync[SYNC_STAGES-2:0], capture_i};
            ext_prev <= ext_sync[SYNC_STAGES-1];
            cap_prev <= cap_sync[SYNC_STAGES-1];
        end
    end

    assign ext_rise = ext_sync[SYNC_STAGES-1] & ~ext_prev;
    assign cap_rise = cap_sync[SYNC_STAGES-1] & ~cap_prev;

    assign wr_fire     = (w_state == W_W) && wvalid;
    assign ctrl_wr     = wr_fire && (w_sel == 3'd0);
    assign ctrl_wval   = apply_strb({28'd0, ctrl}, wdata, wstrb);
    assign load_wval   = apply_strb(load, wdata, wstrb);
    assign int_en_wval = apply_strb({29'd0, int_en}, wdata, wstrb);
    assign cmp_wval    = apply_strb(cmp, wdata, wstrb);

    // Writing EN=0 halts counting at the very edge the write lands.
    assign en_start = ctrl_wr & ctrl_wval[0] & ~ctrl[0];
    assign run      = ctrl[0] & ~(ctrl_wr & ~ctrl_wval[0]);
    assign tick     = run & (ctrl[3] ? ext_rise : 1'b1);
    assign zero_evt = tick & (count == 32'd0);
    assign cmp_evt  = tick & (count == cmp);
    assign stat_clr = (wr_fire && w_sel == 3'd3) ? (wdata[2:0] & {3{wstrb[0]}}) : 3'd0;
    assign stat_set = {cap_rise, cmp_evt, zero_evt};

    // Register file, counter, status and registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl      <= 4'd0;
            load      <= 32'd0;
            count     <= 32'd0;
            stat      <= 3'd0;
            int_en    <= 3'd0;
            capture   <= 32'd0;
            cmp       <= 32'd0;
            trigger_o <= 1'b0;
            pwm_o     <= 1'b0;
        end else begin
            if (ctrl_wr)
                ctrl <= ctrl_wval[3:0];
            else if (zero_evt && !ctrl[1])
                ctrl[0] <= 1'b0;
            if (wr_fire && w_sel == 3'd1) load   <= load_wval;
            if (wr_fire && w_sel == 3'd4) int_en <= int_en_wval[2:0];
            if (wr_fire && w_sel == 3'd6) cmp    <= cmp_wval;

            if (en_start)
                count <= load;
            else if (tick) begin
                if (count == 32'd0)
                    count <= ctrl[1] ? load : count;
                else
                    count <= count - 32'd1;
            end

            stat <= (stat & ~stat_clr) | stat_set;
            if (cap_rise) capture <= count;
            trigger_o <= zero_evt;
            pwm_o     <= ctrl[0] & ctrl[2] & (count < cmp);
        end
    end

endmodule

// File: tb/tb_timer_axi.sv
// Directed bench for timer_axi; register reads are checked through a
// scoreboard of expected values queued when each read is issued.
module tb_timer_axi;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        ext_meas_i, capture_i, pwm_o, trigger_o, irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc;
    logic irq_after_wr;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    timer_axi #(.SYNC_STAGES(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ext_meas_i(ext_meas_i), .capture_i(capture_i),
        .pwm_o(pwm_o), .trigger_o(trigger_o), .irq(irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for DUT handshake", tag);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n;
        @(negedge aclk);
        awaddr  = addr;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        if (!awready) begin timeout("awready"); awvalid = 1'b0; return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!wready && n < 50) begin @(negedge aclk); n++; end
        if (!wready) begin timeout("wready"); wvalid = 1'b0; return; end
        @(posedge aclk); #1;
        wr_cyc       = cyc;
        irq_after_wr = irq;
        wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!bvalid) begin timeout("bvalid"); bready = 1'b0; return; end
        check("bresp", {30'd0, bresp}, 32'd0);
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read_raw(input logic [31:0] addr, output logic [31:0] data,
                                output logic [1:0] resp, output bit ok);
        int n;
        ok   = 1'b0;
        data = 32'hxxxx_xxxx;
        resp = 2'bxx;
        @(negedge aclk);
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        if (!arready) begin timeout("arready"); arvalid = 1'b0; return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!rvalid && n < 50) begin @(negedge aclk); n++; end
        if (!rvalid) begin timeout("rvalid"); rready = 1'b0; return; end
        data = rdata;
        resp = rresp;
        ok   = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
        logic [31:0] got;
        logic [1:0]  resp;
        bit ok;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        axi_read_raw(addr, got, resp, ok);
        if (ok) begin
            check({tag, "_rresp"}, {30'd0, resp}, 32'd0);
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end else begin
            void'(tag_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] cap_val, rd;
        logic [1:0]  resp;
        bit ok;
        int rise_cyc, trig_cnt, hi, cap_c, cap_e, diff;
        int trig_at[$];

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        ext_meas_i = 1'b0; capture_i = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_outputs", {24'd0, awready, wready, bvalid, arready, rvalid,
                              pwm_o, trigger_o, irq}, 32'd0);
        aresetn = 1'b1;
        axi_read(32'h00, 32'd0, "rst_ctrl");
        axi_read(32'h08, 32'd0, "rst_count");
        axi_read(32'h0C, 32'd0, "rst_stat");

        // Register read/write, byte strobes, unmapped offset.
        axi_write(32'h04, 32'hCAFEBABE, 4'hF);
        axi_read(32'h04, 32'hCAFEBABE, "load_rw");
        axi_write(32'h18, 32'h12345678, 4'hF);
        axi_read(32'h18, 32'h12345678, "cmp_rw");
        axi_write(32'h04, 32'h00000011, 4'h1);
        axi_read(32'h04, 32'hCAFEBA11, "load_wstrb");
        axi_write(32'h1C, 32'hFFFFFFFF, 4'hF);
        axi_read(32'h1C, 32'd0, "unmapped");
        axi_write(32'h08, 32'h55, 4'hF);
        axi_read(32'h08, 32'd0, "count_ro");

        // One-shot: irq rises N+1 cycles after the enabling write.
        axi_write(32'h04, 32'd15, 4'hF);
        axi_write(32'h10, 32'd1, 4'hF);
        axi_write(32'h0C, 32'd7, 4'hF);
        axi_write(32'h00, 32'd1, 4'hF);
        rise_cyc = -1;
        trig_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (trigger_o) trig_cnt++;
            if (irq && rise_cyc < 0) rise_cyc = cyc;
        end
        check("oneshot_latency", rise_cyc - wr_cyc, 32'd16);
        check("oneshot_trig_cnt", trig_cnt, 32'd1);
        axi_read(32'h00, 32'd0, "oneshot_ctrl");
        axi_read(32'h08, 32'd0, "oneshot_count");

        // Periodic: trigger every LOAD+1 cycles, STAT clear and re-set.
        axi_write(32'h04, 32'd4, 4'hF);
        axi_write(32'h00, 32'd3, 4'hF);
        for (int i = 0; i < 60 && trig_at.size() < 4; i++) begin
            @(negedge aclk);
            if (trigger_o) trig_at.push_back(cyc);
        end
        if (trig_at.size() < 4) timeout("periodic_triggers");
        else
            for (int i = 1; i < 4; i++)
                check("periodic_spacing", trig_at[i] - trig_at[i-1], 32'd5);
        hi = 0;
        while (!trigger_o && hi < 20) begin @(negedge aclk); hi++; end
        axi_write(32'h0C, 32'd1, 4'hF);
        check("stat_clear_irq", {31'd0, irq_after_wr}, 32'd0);
        hi = 0;
        while (!irq && hi < 10) begin @(negedge aclk); hi++; end
        check("irq_reassert", {31'd0, irq}, 32'd1);
        axi_write(32'h00, 32'd0, 4'hF);

        // Compare and PWM duty.
        axi_write(32'h0C, 32'd7, 4'hF);
        axi_write(32'h04, 32'd100, 4'hF);
        axi_write(32'h18, 32'd40, 4'hF);
        axi_write(32'h00, 32'd7, 4'hF);
        repeat (3) @(negedge aclk);
        hi = 0;
        for (int i = 0; i < 101; i++) begin
            @(negedge aclk);
            if (pwm_o) hi++;
        end
        check("pwm_duty", hi, 32'd40);
        axi_read(32'h0C, 32'd3, "cmp_stat");
        axi_write(32'h00, 32'd0, 4'hF);
        @(negedge aclk);
        check("pwm_off", {31'd0, pwm_o}, 32'd0);

        // Input capture.
        axi_write(32'h0C, 32'd7, 4'hF);
        axi_write(32'h10, 32'd4, 4'hF);
        axi_write(32'h04, 32'd1000, 4'hF);
        axi_write(32'h00, 32'd1, 4'hF);
        repeat (5) @(negedge aclk);
        capture_i = 1'b1;
        cap_c = cyc;
        cap_e = 1000 - (cap_c + 2 - wr_cyc);
        repeat (3) @(negedge aclk);
        capture_i = 1'b0;
        repeat (4) @(negedge aclk);
        check("cap_irq", {31'd0, irq}, 32'd1);
        axi_read_raw(32'h14, cap_val, resp, ok);
        if (!ok) timeout("cap_read");
        else begin
            diff = int'(cap_val) - cap_e;
            checks++;
            assert (diff >= -1 && diff <= 1) else begin
                errors++;
                $error("FAIL cap_value: observed %0d expected %0d +/-1", cap_val, cap_e);
            end
        end
        axi_read(32'h0C, 32'd4, "cap_stat");
        axi_write(32'h00, 32'd0, 4'hF);

        // External event counting.
        axi_write(32'h0C, 32'd7, 4'hF);
        axi_write(32'h10, 32'd1, 4'hF);
        axi_write(32'h04, 32'd3, 4'hF);
        axi_write(32'h00, 32'h9, 4'hF);
        repeat (20) @(negedge aclk);
        axi_read(32'h08, 32'd3, "ext_hold");
        for (int e = 0; e < 3; e++) begin
            @(negedge aclk) ext_meas_i = 1'b1;
            repeat (4) @(negedge aclk);
            ext_meas_i = 1'b0;
            repeat (4) @(negedge aclk);
        end
        axi_read(32'h08, 32'd0, "ext_count3");
        axi_read(32'h0C, 32'd0, "ext_stat3");
        ext_meas_i = 1'b1;
        repeat (4) @(negedge aclk);
        ext_meas_i = 1'b0;
        repeat (4) @(negedge aclk);
        axi_read(32'h0C, 32'd1, "ext_stat4");
        axi_read(32'h00, 32'h8, "ext_ctrl4");
        check("ext_irq", {31'd0, irq}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_axi.md
Name: timer_axi

Overview:
32-bit down-counting general-purpose timer behind an AXI4-Lite slave port. It provides one-shot and periodic modes, a compare event, input capture, an external-event count mode, PWM output, a trigger pulse and a level interrupt. It sits on the peripheral AXI4-Lite interconnect as a memory-mapped IP.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the synchronizers for ext_meas_i and capture_i (minimum 2).

Ports:
aclk  in  1  system clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
awaddr  in  32  write address; bits [4:2] decode the register, others ignored
awprot  in  3  ignored
awvalid/awready  in/out  1  write address handshake
wdata  in  32  write data
wstrb  in  4  byte enables
wvalid/wready  in/out  1  write data handshake
bresp  out  2  always 2'b00 (OKAY)
bvalid/bready  out/in  1  write response handshake
araddr  in  32  read address; bits [4:2] decode
arprot  in  3  ignored
arvalid/arready  in/out  1  read address handshake
rdata  out  32  read data
rresp  out  2  always 2'b00
rvalid/rready  out/in  1  read data handshake
ext_meas_i  in  1  async external event input (count source)
capture_i  in  1  async capture strobe
pwm_o  out  1  PWM output (registered)
trigger_o  out  1  one-cycle pulse on zero event (registered)
irq  out  1  interrupt, level, = |(STAT & INT_EN)

Behaviour:
- Reset: all registers 0; awready/wready/bvalid/arready/rvalid 0; pwm_o, trigger_o, irq 0.
- Register map (word offsets): 0x00 CTRL RW [3:0]; 0x04 LOAD RW; 0x08 COUNT RO; 0x0C STAT RW1C [2:0]; 0x10 INT_EN RW [2:0]; 0x14 CAPTURE RO; 0x18 CMP RW; 0x1C reads 0. Unused bits read 0. Writes to RO or unmapped offsets are ignored, still OKAY. wstrb masks bytes of RW registers.
- CTRL bits: [0] EN, [1] RELOAD (periodic), [2] PWM_EN, [3] EXT (tick on ext_meas_i rising edge).
- Write FSM: IDLE -> AW (awready=1 for one cycle once awvalid seen; latch awaddr) -> W (wready=1 starting the cycle after AW handshake, held until wvalid handshake; register updated at that edge) -> B (bvalid=1 held until bready) -> IDLE. awready and wready are never high in the same cycle.
- Read FSM: IDLE -> arready=1 for one cycle once arvalid seen; at AR handshake latch rdata from the decoded register, assert rvalid next cycle; hold rvalid/rdata until rready -> IDLE. Read and write FSMs are independent.
- Tick: EXT=0 means every cycle while EN=1. EXT=1 means a rising edge of synchronized ext_meas_i while EN=1.
- EN 0->1 via CTRL write loads COUNT<=LOAD at the same edge. Changing LOAD while running affects only the next reload.
- On tick: if COUNT==0, it is a zero event: STAT[0]<=1 and trigger_o=1 for one cycle. With RELOAD, COUNT<=LOAD; otherwise COUNT stays 0 and CTRL.EN<=0 (one-shot). If COUNT!=0, COUNT<=COUNT-1.
- Compare: on tick with COUNT==CMP, STAT[1]<=1.
- Capture: rising edge of synchronized capture_i loads CAPTURE<=COUNT and sets STAT[2], regardless of EN.
- STAT write-1-to-clear. A hardware set in the same cycle as a clear wins (bit stays 1).
- pwm_o registered: EN & PWM_EN & (COUNT < CMP).
- Zero-event latency: with LOAD=N and EXT=0, STAT[0]/irq rises N+1 cycles after the edge that wrote EN.
- CTRL write with EN=0 stops counting immediately; COUNT holds its value.

Test Plan:
- Write LOAD=0xCAFEBABE, read 0x04 -> 0xCAFEBABE; write CMP=0x12345678, read 0x18 -> 0x12345678; bresp/rresp=0.
- LOAD=15, INT_EN=1, CTRL=1 -> irq rises 16 cycles after the CTRL write; trigger_o pulses once; CTRL.EN reads 0; COUNT reads 0.
- CTRL=0x3, LOAD=4 -> trigger_o every 5 cycles. Write STAT=1 -> irq drops, then reasserts on the next zero.
- LOAD=100, CMP=40, CTRL=0x7 -> STAT[1] sets; pwm_o high while COUNT<40, duty 40/101.
- Running timer, pulse capture_i -> CAPTURE equals COUNT at synchronized edge ±1; STAT[2]=1; with INT_EN=4, irq=1.
- CTRL=0x9, LOAD=3, toggle ext_meas_i 4 rising edges -> zero event only after the 4th edge; without edges COUNT holds.
